// File: rtl/alu_operand_sequencer_if.sv
// Operand stream and result stream between the ALU sequencer and its
// neighbours. The slave side is the sequencer; the master side is the
// upstream producer / downstream consumer.
interface alu_operand_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_y;
  logic [1:0] res_op;

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_y, res_op
  );

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_y, res_op
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Feeds a 4-bit combinational ALU one operand nibble at a time (A, B, S),
// waits a programmable settle time, captures Y and offers it downstream.
// One operation in flight at a time; flush aborts whatever is in progress.
module alu_operand_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  alu_operand_sequencer_if.slave        bus,
  output logic [3:0]                    alu_a,
  output logic [3:0]                    alu_b,
  output logic [1:0]                    alu_s,
  input  logic [3:0]                    alu_y,
  output logic                          busy,
  output logic [7:0]                    op_count
);

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_S,
    EXEC,
    RESULT
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state_reg;
  state_t     state_next;
  logic       armed_reg;
  logic [3:0] alu_a_reg;
  logic [3:0] alu_b_reg;
  logic [1:0] alu_s_reg;
  logic [3:0] res_y_reg;
  logic [1:0] res_op_reg;
  logic       res_valid_reg;
  logic [7:0] op_count_reg;
  logic [3:0] settle_cnt_reg;

  logic       in_take;
  logic       res_take;
  logic       settle_done;

  // Ready is a pure decode of registered state, so no path from in_valid.
  assign bus.in_ready = armed_reg &&
                        ((state_reg == GET_A) || (state_reg == GET_B) || (state_reg == GET_S));
  assign in_take      = bus.in_valid && bus.in_ready;
  assign res_take     = res_valid_reg && bus.res_ready;
  assign settle_done  = (state_reg == EXEC) && (settle_cnt_reg == 4'd1);

  assign alu_a         = alu_a_reg;
  assign alu_b         = alu_b_reg;
  assign alu_s         = alu_s_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_y     = res_y_reg;
  assign bus.res_op    = res_op_reg;
  assign op_count      = op_count_reg;
  assign busy          = (state_reg == EXEC) || (state_reg == RESULT);

  // Next-state decode; flush overrides every handshake.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = GET_A;
    end else begin
      case (state_reg)
        GET_A:   if (in_take)     state_next = GET_B;
        GET_B:   if (in_take)     state_next = GET_S;
        GET_S:   if (in_take)     state_next = EXEC;
        EXEC:    if (settle_done) state_next = RESULT;
        RESULT:  if (res_take)    state_next = GET_A;
        default:                  state_next = GET_A;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= GET_A;
    else        state_reg <= state_next;
  end

  // Arm flag: keeps in_ready low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed_reg <= 1'b0;
    else        armed_reg <= 1'b1;
  end

  // Operand capture and settle counter; operands stay put through a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_reg      <= 4'd0;
      alu_b_reg      <= 4'd0;
      alu_s_reg      <= 2'd0;
      settle_cnt_reg <= 4'd0;
    end else if (!flush) begin
      case (state_reg)
        GET_A: if (in_take) alu_a_reg <= bus.in_data;
        GET_B: if (in_take) alu_b_reg <= bus.in_data;
        GET_S: begin
          if (in_take) begin
            alu_s_reg      <= bus.in_data[1:0];
            settle_cnt_reg <= SETTLE_LOAD;
          end
        end
        EXEC:    settle_cnt_reg <= settle_cnt_reg - 4'd1;
        default: ;
      endcase
    end
  end

  // Result capture, delivery handshake and completed-operation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_y_reg     <= 4'd0;
      res_op_reg    <= 2'd0;
      res_valid_reg <= 1'b0;
      op_count_reg  <= 8'd0;
    end else if (flush) begin
      res_valid_reg <= 1'b0;
    end else if (settle_done) begin
      res_y_reg     <= alu_y;
      res_op_reg    <= alu_s_reg;
      res_valid_reg <= 1'b1;
    end else if ((state_reg == RESULT) && res_take) begin
      res_valid_reg <= 1'b0;
      op_count_reg  <= op_count_reg + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: two instances (settle 1 and settle 4)
// with an adder ALU stub, directed scenarios followed by random operations
// checked against a plain arithmetic model of the expected results.
module tb_alu_operand_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       flush     [2];
  logic       in_valid  [2];
  logic [3:0] in_data   [2];
  logic       res_ready [2];
  logic       in_ready  [2];
  logic       res_valid [2];
  logic [3:0] res_y     [2];
  logic [1:0] res_op    [2];
  logic [3:0] alu_a     [2];
  logic [3:0] alu_b     [2];
  logic [1:0] alu_s     [2];
  logic [3:0] alu_y     [2];
  logic       busy      [2];
  logic [7:0] op_count  [2];

  alu_operand_sequencer_if bus0 ();
  alu_operand_sequencer_if bus1 ();

  assign bus0.in_valid  = in_valid[0];
  assign bus0.in_data   = in_data[0];
  assign bus0.res_ready = res_ready[0];
  assign in_ready[0]    = bus0.in_ready;
  assign res_valid[0]   = bus0.res_valid;
  assign res_y[0]       = bus0.res_y;
  assign res_op[0]      = bus0.res_op;

  assign bus1.in_valid  = in_valid[1];
  assign bus1.in_data   = in_data[1];
  assign bus1.res_ready = res_ready[1];
  assign in_ready[1]    = bus1.in_ready;
  assign res_valid[1]   = bus1.res_valid;
  assign res_y[1]       = bus1.res_y;
  assign res_op[1]      = bus1.res_op;

  // ALU stub: Y = A + B mod 16
  assign alu_y[0] = alu_a[0] + alu_b[0];
  assign alu_y[1] = alu_a[1] + alu_b[1];

  alu_operand_sequencer #(.SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]), .bus(bus0.slave),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_s(alu_s[0]), .alu_y(alu_y[0]),
    .busy(busy[0]), .op_count(op_count[0])
  );

  alu_operand_sequencer #(.SETTLE_CYCLES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]), .bus(bus1.slave),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_s(alu_s[1]), .alu_y(alu_y[1]),
    .busy(busy[1]), .op_count(op_count[1])
  );

  int total = 0;
  int bad = 0;
  int exp_cnt [2];

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one word starting at a negedge; returns at the negedge after the handshake.
  task automatic put_word(input int d, input logic [3:0] w);
    int n;
    n = 0;
    in_valid[d] = 1'b1;
    in_data[d]  = w;
    while (!in_ready[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      chk("in_ready_timeout", 0, 1);
      in_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  // Count cycles from the S handshake until res_valid appears.
  task automatic wait_result(input int d);
    int k;
    k = 0;
    while (!res_valid[d] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, settle_of(d));
  endtask

  task automatic do_op(input int d, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] sw, input int gap, input int stall);
    int ey;
    ey = (int'(a) + int'(b)) % 16;
    res_ready[d] = (stall == 0);
    put_word(d, a);
    repeat (gap) @(negedge clk);
    put_word(d, b);
    repeat (gap) @(negedge clk);
    put_word(d, sw);
    wait_result(d);
    chk("res_y", res_y[d], ey);
    chk("res_op", res_op[d], sw % 4);
    chk("alu_a", alu_a[d], a);
    chk("alu_b", alu_b[d], b);
    for (int i = 0; i < stall; i++) begin
      chk("held_valid", res_valid[d], 1);
      chk("held_y", res_y[d], ey);
      chk("held_in_ready", in_ready[d], 0);
      @(negedge clk);
    end
    res_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_cnt[d] = (exp_cnt[d] + 1) % 256;
    chk("delivered_valid", res_valid[d], 0);
    chk("op_count", op_count[d], exp_cnt[d]);
    chk("ready_again", in_ready[d], 1);
    res_ready[d] = 1'b0;
    $display("op dut%0d a=%0d b=%0d s=%0d -> y=%0d op=%0d count=%0d",
             d, a, b, sw % 4, res_y[d], res_op[d], op_count[d]);
  endtask

  task automatic pulse_flush(input int d);
    flush[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush[d] = 1'b0;
  endtask

  initial begin
    logic [3:0] ra, rb, rs;
    for (int d = 0; d < 2; d++) begin
      flush[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = 4'd0; res_ready[d] = 1'b0;
      exp_cnt[d] = 0;
    end

    // Reset state and arming
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready[0], 0);
    chk("rst_res_valid", res_valid[0], 0);
    chk("rst_alu_a", alu_a[0], 0);
    chk("rst_op_count", op_count[0], 0);
    chk("rst_busy", busy[0], 0);
    rst_n = 1'b1;
    #1;
    chk("arm_first_cycle", in_ready[0], 0);
    @(negedge clk);
    chk("arm_second_cycle", in_ready[0], 1);
    chk("arm_second_cycle_d1", in_ready[1], 1);

    // Basic op, back-to-back words, res_ready high throughout
    do_op(0, 4'd3, 4'd3, 4'd1, 0, 0);

    // Backpressure with wrap, then check a single increment
    do_op(0, 4'd15, 4'd2, 4'd0, 0, 5);
    @(negedge clk);
    chk("single_increment", op_count[0], exp_cnt[0]);

    // Gapped input on the settle-4 instance
    do_op(1, 4'd5, 4'd3, 4'd2, 2, 0);

    // Flush after A and B: partial operation discarded
    put_word(0, 4'd4);
    put_word(0, 4'd5);
    pulse_flush(0);
    chk("flush_keeps_a", alu_a[0], 4);
    chk("flush_to_get_a", in_ready[0], 1);
    do_op(0, 4'd1, 4'd1, 4'd3, 0, 0);

    // Flush in RESULT with res_ready also high
    put_word(0, 4'd7);
    put_word(0, 4'd6);
    put_word(0, 4'd2);
    wait_result(0);
    flush[0] = 1'b1;
    res_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush[0] = 1'b0;
    res_ready[0] = 1'b0;
    chk("flush_res_valid", res_valid[0], 0);
    chk("flush_op_count", op_count[0], exp_cnt[0]);
    chk("flush_busy", busy[0], 0);
    $display("flush in RESULT dut0 count=%0d", op_count[0]);

    // Asynchronous reset in the middle of EXEC on the settle-4 instance
    put_word(1, 4'd9);
    put_word(1, 4'd9);
    put_word(1, 4'd3);
    chk("exec_busy", busy[1], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_alu_a", alu_a[1], 0);
    chk("async_alu_b", alu_b[1], 0);
    chk("async_alu_s", alu_s[1], 0);
    chk("async_res_y", res_y[1], 0);
    chk("async_res_op", res_op[1], 0);
    chk("async_op_count", op_count[1], 0);
    chk("async_res_valid", res_valid[1], 0);
    chk("async_busy", busy[1], 0);
    chk("async_in_ready", in_ready[1], 0);
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_result_after_reset", res_valid[1], 0);
    chk("idle_after_reset", busy[1], 0);
    $display("reset mid-EXEC dut1 count=%0d", op_count[1]);

    // 256 random operations: exercises the datapath and the counter wrap
    for (int i = 0; i < 256; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 4'($urandom_range(0, 15));
      do_op(0, ra, rb, rs, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    chk("wrap_to_zero", op_count[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
